// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types and constants plus the arbiter's index/state types.
// Used by cbus_arbiter, cbus_arb_picker and cbus_arbiter_if.
package cbus_arbiter_pkg;

    localparam logic [1:0] MSIZE4 = 2'd2;

    // Burst length is encoded as beats-1
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    localparam int CBUS_ARB_MAX_INPUTS = 8;
    typedef logic [$clog2(CBUS_ARB_MAX_INPUTS)-1:0] cbus_arb_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cbus_arb_state_e;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of upstream request/response arrays and the single downstream port.
import cbus_arbiter_pkg::*;

interface cbus_arbiter_if #(
    parameter int NUM_INPUTS = 2
);
    cbus_req_t  ireqs  [NUM_INPUTS];
    cbus_resp_t oresps [NUM_INPUTS];
    cbus_req_t  oreq;
    cbus_resp_t iresp;

    modport slave (
        input  ireqs,
        input  iresp,
        output oresps,
        output oreq
    );

    modport master (
        output ireqs,
        output iresp,
        input  oresps,
        input  oreq
    );
endinterface

// File: rtl/cbus_arb_picker.sv
// Combinational grant pick. Define CBUS_ARB_ROUND_ROBIN_EN for round-robin
// starting after last_index_i; otherwise fixed priority with index 0 highest.
module cbus_arb_picker #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [IDX_W-1:0]      last_index_i,
    output logic [IDX_W-1:0]      pick_o,
    output logic                  any_valid_o
);

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the nearest valid master after last_index wins
    always_comb begin
        pick_o      = '0;
        any_valid_o = 1'b0;
        cand        = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_index_i) + k) % NUM_INPUTS);
            if (valid_i[cand]) begin
                pick_o      = cand;
                any_valid_o = 1'b1;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_index_i;

    always_comb begin
        pick_o      = '0;
        any_valid_o = 1'b0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                pick_o      = IDX_W'(i);
                any_valid_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 cache-bus arbiter: grants one master for a whole burst, one idle
// cycle between bursts. Pick policy selected by CBUS_ARB_ROUND_ROBIN_EN.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input logic            clk,
    input logic            resetn,
    cbus_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    cbus_arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [IDX_W-1:0]        last_index_q, last_index_d;
    logic [IDX_W-1:0]        pick;
    logic                    any_valid;
    logic [NUM_INPUTS-1:0]   valid_vec;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = bus.ireqs[i].valid;
        end
    end

    cbus_arb_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .valid_i      (valid_vec),
        .last_index_i (last_index_q),
        .pick_o       (pick),
        .any_valid_o  (any_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            index_q      <= '0;
            last_index_q <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            last_index_q <= last_index_d;
        end
    end

    // Data path is a pure mux while BUSY so write data follows the master each beat
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        last_index_d = last_index_q;
        bus.oreq     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.oresps[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    index_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.oreq            = bus.ireqs[index_q];
                bus.oresps[index_q] = bus.iresp;
                if (bus.iresp.ready && bus.iresp.last) begin
                    state_d      = IDLE;
                    last_index_d = index_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of upstream cache-bus masters (2..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ireqs  input  NUM_INPUTS x cbus_req_t  requests from upstream masters.
REQ-005 SHALL have port oresps  output  NUM_INPUTS x cbus_resp_t  responses to upstream masters.
REQ-006 SHALL have port oreq  output  cbus_req_t  request to the single downstream memory port.
REQ-007 SHALL have port iresp  input  cbus_resp_t  response from the downstream memory port.

Function
REQ-008 SHALL implement FSM states IDLE and BUSY, plus registers index (granted master) and last_index (previous grant).
REQ-009 In IDLE with at least one ireqs[i].valid, SHALL register index = picked master and enter BUSY next cycle; no other state change.
REQ-010 In IDLE, oreq SHALL be all-zero and every oresps[i] SHALL be all-zero.
REQ-011 In BUSY, oreq SHALL equal ireqs[index] combinationally, so per-beat write data changes propagate with zero latency.
REQ-012 In BUSY, oresps[index] SHALL equal iresp; all other oresps SHALL be all-zero (ready=0, last=0).
REQ-013 In BUSY, on iresp.ready && iresp.last, SHALL return to IDLE, set last_index = index; no new grant in that cycle.
REQ-014 Grant latency: request valid in cycle t (arbiter IDLE) -> oreq.valid in cycle t+1; back-to-back transactions have one IDLE bubble.
REQ-015 Grant SHALL be held through all beats (len up to MLEN16); a non-granted master's valid SHALL not affect oreq.
REQ-016 If ireqs[index].valid drops while BUSY, SHALL stay BUSY, forward valid=0, and wait for iresp.last.
REQ-017 Requests arriving while BUSY SHALL wait; arbiter never drops a request held valid by its master.
REQ-018 Simultaneous valid from several masters in IDLE: exactly one granted, per REQ-021/REQ-022.
REQ-019 index SHALL be $clog2(NUM_INPUTS) bits wide; round-robin pointer arithmetic wraps modulo NUM_INPUTS.

Reset
REQ-020 While resetn=0 at a clock edge: state=IDLE, index=0, last_index=NUM_INPUTS-1, so oreq.valid=0 and all oresps zero next cycle; reset mid-transaction abandons it without finishing beats.

Configuration
REQ-021 With CBUS_ARB_ROUND_ROBIN_EN defined, the pick SHALL be the first valid master scanning last_index+1, last_index+2, ... modulo NUM_INPUTS.
REQ-022 Without CBUS_ARB_ROUND_ROBIN_EN, the pick SHALL be the lowest-index valid master (fixed priority, index 0 highest); last_index is still maintained but unused.

Structure
REQ-023 cbus_req_t, cbus_resp_t, MSIZE*/MLEN* constants SHALL come from the existing shared common package; the arbiter index typedef SHALL be added there.
REQ-024 The pick logic SHALL be one combinational sub-module, cbus_arb_picker (inputs: valid vector, last_index; output: picked index, any_valid).

Verification
REQ-025 Single master 0 read MLEN16 at addr 0x8000_0040 -> oreq.valid at t+1 with addr 0x8000_0040, 16 iresp beats forwarded to oresps[0] only, IDLE after beat 16.
REQ-026 Masters 0 and 1 valid same cycle from reset -> round-robin build: 0 first, then 1; fixed build: 0 then 1; both then re-request -> RR grants 0 after 1, fixed grants 0.
REQ-027 Master 1 write 16 beats with data 0x1000+beat while master 0 asserts valid mid-burst -> all 16 oreq.data values forwarded unchanged, master 0 granted only after last, oresps[0].ready=0 throughout.
REQ-028 resetn=0 at beat 5 of an 8-beat read -> next cycle oreq.valid=0, state IDLE; fresh request after reset granted in one cycle.
REQ-029 Granted master drops valid after beat 3 of MLEN4 -> arbiter stays BUSY until iresp.last, forwards valid=0, then returns to IDLE.
REQ-030 NUM_INPUTS=3, all valid continuously, RR build -> grant order 0,1,2,0,1,2 with one idle cycle between transactions.
